// File: rtl/memory_access_mod_pkg.sv
// Shared pipeline definitions for the memory stage: FSM encodings, data-memory
// widths, the default ack timeout and the MEM/WB payload.
package memory_access_mod_pkg;

    localparam int unsigned DMEM_ADDR_W     = 32;
    localparam int unsigned DMEM_DATA_W     = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    // One MEM/WB pipeline entry.
    typedef struct packed {
        logic                   reg_write;
        logic                   result_src;
        logic                   err;
        logic [DMEM_DATA_W-1:0] read_data;
        logic [DMEM_DATA_W-1:0] alu_result;
        logic [DMEM_ADDR_W-1:0] pc_plus4;
        logic [REG_ADDR_W-1:0]  rd;
    } mem_wb_t;

endpackage

// File: rtl/memory_access_mod_mem_wb_reg.sv
// MEM/WB pipeline register. Each cycle it either loads a new entry or, when
// bubble_i is set, clears the write-enable and error flag while holding data.
//   clk, rst   : clock, async active-low reset
//   bubble_i   : insert bubble instead of loading entry_i
//   entry_i    : next W-stage entry
//   entry_o    : registered W-stage entry
module mem_wb_reg
    import memory_access_mod_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble_i,
    input  mem_wb_t entry_i,
    output mem_wb_t entry_o
);

    mem_wb_t entry_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else if (bubble_i) begin
            entry_q.reg_write <= 1'b0;
            entry_q.err       <= 1'b0;
        end else begin
            entry_q <= entry_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/mux2.sv
// Generic 2:1 mux.
//   d0_i, d1_i : data inputs
//   sel_i      : 1 selects d1_i
//   y_o        : combinational output
module mux2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/memory_access_mod.sv
// Memory stage of the 5-stage RISC-V pipeline. Issues word loads/stores over a
// req/ack data-memory port, stalls upstream while an access is outstanding,
// aborts after TIMEOUT cycles without ack, and registers the MEM/WB bundle.
//   clk, rst                 : clock, async active-low reset
//   *M inputs                : EX/MEM bundle
//   dmem_*                   : data-memory port (req/we/addr/wdata out, ack/rdata in)
//   StallM                   : combinational upstream freeze
//   *W outputs               : registered MEM/WB bundle, ErrW one-cycle error flag
//   ResultW                  : write-back value (combinational from W registers)
module memory_access_mod
    import memory_access_mod_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWriteM,
    input  logic                   ResultSrcM,
    input  logic                   MemwriteM,
    input  logic [DMEM_DATA_W-1:0] ALUresultM,
    input  logic [DMEM_DATA_W-1:0] WriteDataM,
    input  logic [DMEM_ADDR_W-1:0] PCplus4M,
    input  logic [REG_ADDR_W-1:0]  RdM,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [DMEM_DATA_W-1:0] dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [DMEM_DATA_W-1:0] dmem_rdata,
    output logic                   StallM,
    output logic                   RegWriteW,
    output logic                   ResultSrcW,
    output logic [DMEM_DATA_W-1:0] ReadDataW,
    output logic [DMEM_DATA_W-1:0] ALUresultW,
    output logic [DMEM_ADDR_W-1:0] PCplus4W,
    output logic [REG_ADDR_W-1:0]  RdW,
    output logic [DMEM_DATA_W-1:0] ResultW,
    output logic                   ErrW
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    mem_op_c;
    logic    misaligned_c;
    logic    req_c;
    logic    stall_c;
    logic    complete_c;
    logic    abort_c;
    mem_wb_t entry_d;
    mem_wb_t entry_q;

    assign mem_op_c     = ResultSrcM | MemwriteM;
    assign misaligned_c = mem_op_c & (ALUresultM[1:0] != 2'b00);

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, handshake and stall decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        abort_c    = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                if (mem_op_c && !misaligned_c) begin
                    req_c = 1'b1;
                    if (dmem_ack) begin
                        complete_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = MS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            MS_WAIT: begin
                if (dmem_ack) begin
                    req_c      = 1'b1;
                    complete_c = 1'b1;
                    state_d    = MS_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
                    // Request dropped this cycle; the M instruction retires as an error.
                    abort_c = 1'b1;
                    state_d = MS_IDLE;
                    cnt_d   = '0;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = MS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Gated by rst so the port goes quiet the instant reset asserts.
    assign dmem_req   = req_c & rst;
    assign StallM     = stall_c & rst;
    assign dmem_we    = MemwriteM & dmem_req;
    assign dmem_addr  = ALUresultM;
    assign dmem_wdata = WriteDataM;

    // Next W entry; read data only changes when a load actually completes.
    always_comb begin
        entry_d            = '0;
        entry_d.reg_write  = RegWriteM & ~misaligned_c & ~abort_c;
        entry_d.result_src = ResultSrcM;
        entry_d.err        = misaligned_c | abort_c;
        entry_d.read_data  = (complete_c && ResultSrcM) ? dmem_rdata : entry_q.read_data;
        entry_d.alu_result = ALUresultM;
        entry_d.pc_plus4   = PCplus4M;
        entry_d.rd         = RdM;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (stall_c),
        .entry_i  (entry_d),
        .entry_o  (entry_q)
    );

    assign RegWriteW  = entry_q.reg_write;
    assign ResultSrcW = entry_q.result_src;
    assign ErrW       = entry_q.err;
    assign ReadDataW  = entry_q.read_data;
    assign ALUresultW = entry_q.alu_result;
    assign PCplus4W   = entry_q.pc_plus4;
    assign RdW        = entry_q.rd;

    mux2 #(
        .WIDTH (DMEM_DATA_W)
    ) u_result_mux (
        .d0_i  (entry_q.alu_result),
        .d1_i  (entry_q.read_data),
        .sel_i (entry_q.result_src),
        .y_o   (ResultW)
    );

endmodule

// File: tb/tb_memory_access_mod.sv
// Directed self-checking bench for memory_access_mod. Inputs change on the
// falling edge; combinational outputs are sampled 1 ns later and registered
// outputs 1 ns after the rising edge.
module tb_memory_access_mod;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        ResultSrcM;
    logic        MemwriteM;
    logic [31:0] ALUresultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCplus4M;
    logic [4:0]  RdM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUresultW;
    logic [31:0] PCplus4W;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        ErrW;

    int n_checks;
    int n_errors;
    int stall_cycles;
    int store_seen;

    memory_access_mod #(
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemwriteM  (MemwriteM),
        .ALUresultM (ALUresultM),
        .WriteDataM (WriteDataM),
        .PCplus4M   (PCplus4M),
        .RdM        (RdM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ReadDataW  (ReadDataW),
        .ALUresultW (ALUresultW),
        .PCplus4W   (PCplus4W),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .ErrW       (ErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic rs, input logic mw, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] rd);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemwriteM  = mw;
        ALUresultM = alu;
        WriteDataM = wd;
        PCplus4M   = pc;
        RdM        = rd;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_RegWriteW", 32'(RegWriteW), 32'd0);
        check("rst_ErrW", 32'(ErrW), 32'd0);
        check("rst_ResultW", ResultW, 32'h0);
        check("rst_RdW", 32'(RdW), 32'd0);
        check("rst_StallM", 32'(StallM), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);

        // ALU op passes through in one cycle
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_0014, 5'd3);
        #1;
        check("alu_req", 32'(dmem_req), 32'd0);
        check("alu_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        check("alu_ALUresultW", ALUresultW, 32'h5);
        check("alu_RdW", 32'(RdW), 32'd3);
        check("alu_ResultW", ResultW, 32'h5);
        check("alu_RegWriteW", 32'(RegWriteW), 32'd1);
        check("alu_PCplus4W", PCplus4W, 32'h14);

        // Zero-wait load
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0018, 5'd5);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld0_req", 32'(dmem_req), 32'd1);
        check("ld0_we", 32'(dmem_we), 32'd0);
        check("ld0_addr", dmem_addr, 32'h100);
        check("ld0_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        check("ld0_ResultW", ResultW, 32'hDEAD_BEEF);
        check("ld0_RegWriteW", 32'(RegWriteW), 32'd1);
        check("ld0_RdW", 32'(RdW), 32'd5);

        // Store with 3 wait states
        stall_cycles = 0;
        store_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0000_001C, 5'd0);
            dmem_ack = (i == 3);
            dmem_rdata = 32'h5555_AAAA;
            #1;
            check("st_req", 32'(dmem_req), 32'd1);
            check("st_we", 32'(dmem_we), 32'd1);
            check("st_addr", dmem_addr, 32'h200);
            check("st_wdata", dmem_wdata, 32'h1234_5678);
            check("st_stall", 32'(StallM), (i < 3) ? 32'd1 : 32'd0);
            if (StallM) stall_cycles++;
            if (dmem_req && dmem_we && dmem_ack) store_seen++;
            @(posedge clk); #1;
            check("st_RegWriteW", 32'(RegWriteW), 32'd0);
            check("st_ErrW", 32'(ErrW), 32'd0);
            check("st_ALUresultW", ALUresultW, (i < 3) ? 32'h100 : 32'h200);
        end
        check("st_stall_cycles", 32'(stall_cycles), 32'd3);
        check("st_seen_once", 32'(store_seen), 32'd1);
        check("st_ReadDataW_held", ReadDataW, 32'hDEAD_BEEF);

        // Misaligned load: no request, one-cycle error
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0020, 5'd6);
        dmem_ack = 1'b0;
        #1;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        check("mis_ErrW", 32'(ErrW), 32'd1);
        check("mis_RegWriteW", 32'(RegWriteW), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0, 32'h0000_0024, 5'd4);
        @(posedge clk); #1;
        check("mis_ErrW_clear", 32'(ErrW), 32'd0);
        check("mis_next_ResultW", ResultW, 32'h7);
        check("mis_next_RegWriteW", 32'(RegWriteW), 32'd1);

        // Load never acked: 16 stall cycles then abort
        stall_cycles = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_0028, 5'd8);
            #1;
            check("to_req", 32'(dmem_req), (i < 16) ? 32'd1 : 32'd0);
            check("to_stall", 32'(StallM), (i < 16) ? 32'd1 : 32'd0);
            if (StallM) stall_cycles++;
            @(posedge clk); #1;
            check("to_ErrW", 32'(ErrW), (i == 16) ? 32'd1 : 32'd0);
            check("to_RegWriteW", 32'(RegWriteW), 32'd0);
        end
        check("to_stall_cycles", 32'(stall_cycles), 32'd16);

        // Next ALU op flows; stray ack with no request is ignored
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0009, 32'h0, 32'h0000_002C, 5'd6);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("post_to_req", 32'(dmem_req), 32'd0);
        check("post_to_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        check("post_to_ResultW", ResultW, 32'h9);
        check("post_to_ErrW", 32'(ErrW), 32'd0);
        check("post_to_RegWriteW", 32'(RegWriteW), 32'd1);
        check("post_to_ReadDataW", ReadDataW, 32'hDEAD_BEEF);

        // Reset asserted while in WAIT
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_0030, 5'd9);
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("rw_wait_stall", 32'(StallM), 32'd1);
        check("rw_wait_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_stall", 32'(StallM), 32'd0);
        check("rw_RegWriteW", 32'(RegWriteW), 32'd0);
        check("rw_ResultW", ResultW, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h0000_0034, 5'd7);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        #1;
        check("rw_ld_req", 32'(dmem_req), 32'd1);
        check("rw_ld_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        check("rw_ld_ResultW", ResultW, 32'h0BAD_F00D);
        check("rw_ld_RegWriteW", 32'(RegWriteW), 32'd1);
        check("rw_ld_RdW", 32'(RdW), 32'd7);

        @(negedge clk);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_access_mod.md
# memory_access_mod

Memory stage of the 5-stage RISC-V pipeline: accepts the EX/MEM bundle produced by the execute stage, runs word loads/stores against a data-memory port with a req/ack handshake (variable wait states), raises a pipeline stall while an access is outstanding, and registers the MEM/WB bundle. It also produces `ResultW`, the write-back value fed to the register file and to the execute-stage forwarding muxes.

## Interface
- `TIMEOUT`, 16: maximum cycles to wait for `dmem_ack` before aborting the access.
- `clk` in 1: clock. All state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `RegWriteM` in 1: instruction writes the register file.
- `ResultSrcM` in 1: 1 means load; write-back takes memory data.
- `MemwriteM` in 1: store.
- `ALUresultM` in 32: effective address, or ALU result for non-memory instructions.
- `WriteDataM` in 32: store data.
- `PCplus4M` in 32: PC+4, passed through.
- `RdM` in 5: destination register.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 means write.
- `dmem_addr` out 32: word address, equal to `ALUresultM`.
- `dmem_wdata` out 32: equal to `WriteDataM`.
- `dmem_ack` in 1: access complete. Read data is valid in the same cycle.
- `dmem_rdata` in 32: load data.
- `StallM` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `RegWriteW`, `ResultSrcW` out 1 each: registered controls.
- `ReadDataW`, `ALUresultW`, `PCplus4W` out 32 each: registered data.
- `RdW` out 5: registered destination register.
- `ResultW` out 32: `ResultSrcW ? ReadDataW : ALUresultW`.
- `ErrW` out 1: registered one-cycle flag for a misaligned address or a timeout.

## Operation
- A memory operation is `ResultSrcM | MemwriteM`. Loads and stores are word-only.
- Misaligned access (`ALUresultM[1:0] != 0`) on a memory operation:
  - no request is issued;
  - the W-stage entry is written with `RegWriteW=0` and `ErrW=1`;
  - no stall.
- FSM states: IDLE, WAIT.
- IDLE:
  - With an aligned memory operation, drive `dmem_req=1` combinationally, with `dmem_we=MemwriteM` and address/data from the M inputs.
  - If `dmem_ack` is high in the same cycle, the access completes (zero wait state), the W register captures, and the FSM stays in IDLE.
  - Otherwise assert `StallM`, go to WAIT and load the wait counter with 1.
- WAIT:
  - `dmem_req` and `StallM` stay high.
  - Upstream holds the M inputs stable, so the request stays stable.
  - On `dmem_ack`: the W register captures (`ReadDataW<=dmem_rdata` for loads), `StallM` drops combinationally in that cycle, and the FSM goes to IDLE.
  - If the counter reaches `TIMEOUT` with no ack: abort. `dmem_req` drops, the W entry is written with `RegWriteW=0` and `ErrW=1`, and the FSM goes to IDLE.
  - The counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.
- Every cycle that `StallM=1` and no completion occurs, the W register loads a bubble: `RegWriteW=0`, `ErrW=0`, data fields unchanged. This prevents a repeated write-back.
- Non-memory instructions pass straight through to the W register the next cycle.
- A store writes `RegWriteW` as given, which the decoder sets to 0.
- `dmem_ack` received in IDLE with no request is ignored.
- Reset mid-access: the FSM returns to IDLE and `dmem_req` drops immediately (asynchronous). The outstanding access is abandoned; the memory model must tolerate a dropped request.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0;
  - `RegWriteW`, `ResultSrcW`, `ErrW` = 0;
  - `ReadDataW`, `ALUresultW`, `PCplus4W` = 0, `RdW` = 0;
  - `ResultW` = 0.
  - `StallM` and `dmem_req` are 0 during reset.
- Latency:
  - Non-memory and zero-wait accesses: M to W in 1 cycle.
  - An access with N wait states stalls N cycles and reaches W N+1 cycles after entering M.
- `StallM` and `dmem_req` are combinational from FSM state and the M inputs. `ResultW` is combinational from W registers only.
- Maximum stall is `TIMEOUT` cycles. Then `ErrW` pulses for exactly 1 cycle.

## Structure
- Shared pipeline package/header holds:
  - FSM state encodings `MS_IDLE`, `MS_WAIT`;
  - the `dmem_*` width constants;
  - the default `TIMEOUT`.
- One sub-module, `mem_wb_reg`: the MEM/WB register with load/bubble select and async active-low reset.
- The FSM, counter and misalign check live in the top module.
- The `ResultW` mux reuses the existing 2:1 mux (`mux2`).

## Test plan
- Reset then ALU op (`ALUresultM=0x0000_0005`, `RdM=3`, `RegWriteM=1`) -> next cycle `ALUresultW=5`, `RdW=3`, `ResultW=5`, no `dmem_req`.
- Load at `0x100`, ack same cycle with rdata `0xDEAD_BEEF` -> `StallM` never high; next cycle `ResultW=0xDEADBEEF`, `RegWriteW=1`.
- Store at `0x200`, data `0x1234_5678`, ack after 3 wait states -> `StallM` high 3 cycles; `dmem_we=1`; addr/data stable throughout; `RegWriteW=0` bubbles; store seen exactly once.
- Load at `0x103` -> no `dmem_req`; next cycle `ErrW=1`, `RegWriteW=0`; then `ErrW=0`.
- Load never acked with `TIMEOUT=16` -> `StallM` high 16 cycles, then `dmem_req` drops, `ErrW` pulses once, FSM back in IDLE, next ALU op flows normally.
- Reset asserted in WAIT -> `dmem_req`, `StallM`, `RegWriteW` go 0 immediately; after release, a zero-wait load completes normally.
